// File: rtl/rst_req_seq_if.sv
// Reset request sequencer bus: request causes, downstream acknowledge,
// and the sequencer's registered status outputs.
interface rst_req_seq_if;
  logic       sw_req_i;
  logic       wdt_req_i;
  logic       ack_i;
  logic       rst_req_o;
  logic       busy_o;
  logic [1:0] cause_o;
  logic       timeout_o;

  modport master (
    input  sw_req_i,
    input  wdt_req_i,
    input  ack_i,
    output rst_req_o,
    output busy_o,
    output cause_o,
    output timeout_o
  );

  modport slave (
    output sw_req_i,
    output wdt_req_i,
    output ack_i,
    input  rst_req_o,
    input  busy_o,
    input  cause_o,
    input  timeout_o
  );
endinterface

// File: rtl/rst_req_seq.sv
// Reset request sequencer: drives a registered reset request through an
// assert / wait-ack / hold / release / wait-ack-low handshake.
module rst_req_seq #(
  parameter int unsigned PulseCycles   = 16,
  parameter int unsigned TimeoutCycles = 1024,
  localparam int unsigned MaxCycles =
    (PulseCycles > TimeoutCycles) ? PulseCycles : TimeoutCycles,
  localparam int unsigned CntWidth = $clog2(MaxCycles + 1)
) (
  input logic           clk_i,
  input logic           rst_i,
  rst_req_seq_if.master bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ASSERT  = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam logic [1:0] C_POR = 2'b00;
  localparam logic [1:0] C_SW  = 2'b01;
  localparam logic [1:0] C_WDT = 2'b10;

  localparam logic [CntWidth-1:0] TMO_LAST =
    CntWidth'(TimeoutCycles - 1);
  localparam logic [CntWidth-1:0] PULSE_LAST =
    CntWidth'(PulseCycles - 1);

  logic [1:0]          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]          cause_q, cause_d;
  logic [1:0]          pcause_q, pcause_d;
  logic                pend_q, pend_d;
  logic                tmo_q, tmo_d;
  logic                req_q, busy_q;
  logic                sw, wdt, ack;
  logic                start_wdt, pend_wdt;

  assign sw  = bus.sw_req_i;
  assign wdt = bus.wdt_req_i;
  assign ack = bus.ack_i;

  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CntWidth'(1);
  assign pend_wdt  = pend_q & (pcause_q == C_WDT);
  assign start_wdt = wdt | pend_wdt;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    pcause_d = pcause_q;
    pend_d   = pend_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (sw | wdt | pend_q) begin
          state_d = S_ASSERT;
          cnt_d   = '0;
          pend_d  = 1'b0;
          cause_d = start_wdt ? C_WDT : C_SW;
        end
      end
      S_ASSERT: begin
        cnt_d = cnt_inc;
        // requests here join the running reset
        if (wdt) cause_d = C_WDT;
        if (ack) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      S_HOLD: begin
        cnt_d = cnt_inc;
        if (cnt_q == PULSE_LAST) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end
      end
      S_RELEASE: begin
        cnt_d = cnt_inc;
        if (!ack) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
    endcase
    if (state_q == S_HOLD || state_q == S_RELEASE) begin
      if (wdt) begin
        pend_d   = 1'b1;
        pcause_d = C_WDT;
      end else if (sw) begin
        pend_d = 1'b1;
        if (!pend_wdt) pcause_d = C_SW;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_ASSERT;
      cnt_q    <= '0;
      cause_q  <= C_POR;
      pcause_q <= C_POR;
      pend_q   <= 1'b0;
      tmo_q    <= 1'b0;
      req_q    <= 1'b1;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      pcause_q <= pcause_d;
      pend_q   <= pend_d;
      tmo_q    <= tmo_d;
      req_q    <= (state_d == S_ASSERT) || (state_d == S_HOLD);
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign bus.rst_req_o = req_q;
  assign bus.busy_o    = busy_q;
  assign bus.cause_o   = cause_q;
  assign bus.timeout_o = tmo_q;

endmodule

// File: tb/tb_rst_req_seq.sv
// Bench for rst_req_seq: vector table, directed handshake corners and
// random traffic against a phase/age reference model.
module tb_rst_req_seq;
  localparam int P = 16;
  localparam int T = 1024;

  localparam int PH_IDLE    = 0;
  localparam int PH_ASSERT  = 1;
  localparam int PH_HOLD    = 2;
  localparam int PH_RELEASE = 3;

  logic clk = 1'b0;
  logic rst;

  rst_req_seq_if bus();

  rst_req_seq #(
    .PulseCycles  (P),
    .TimeoutCycles(T)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit auto_ack = 1'b0;

  // reference model: phase, cycles spent in phase, causes as
  // priority numbers (0 none/POR, 1 SW, 2 WDT) merged with max
  int m_ph, m_age, m_cause, m_pend;
  bit m_tmo;

  typedef struct {
    bit         sw;
    bit         wdt;
    bit         e_rst;
    bit         e_busy;
    logic [1:0] e_cause;
  } vec_t;

  vec_t tbl [6];

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  task automatic m_reset();
    m_ph = PH_ASSERT; m_age = 0;
    m_cause = 0; m_pend = 0; m_tmo = 1'b0;
  endtask

  task automatic m_enter(int ph);
    m_ph = ph; m_age = 0;
  endtask

  task automatic m_step();
    int req;
    req = imax(bus.wdt_req_i ? 2 : 0, bus.sw_req_i ? 1 : 0);
    if (m_ph == PH_HOLD || m_ph == PH_RELEASE)
      m_pend = imax(m_pend, req);
    m_age++;
    case (m_ph)
      PH_IDLE: begin
        if (imax(req, m_pend) != 0) begin
          m_cause = imax(req, m_pend);
          m_pend = 0;
          m_enter(PH_ASSERT);
        end
      end
      PH_ASSERT: begin
        if (req == 2) m_cause = 2;
        if (bus.ack_i) m_enter(PH_HOLD);
        else if (m_age == T) begin
          m_tmo = 1'b1; m_enter(PH_HOLD);
        end
      end
      PH_HOLD: if (m_age == P) m_enter(PH_RELEASE);
      default: begin
        if (!bus.ack_i) m_enter(PH_IDLE);
        else if (m_age == T) begin
          m_tmo = 1'b1; m_enter(PH_IDLE);
        end
      end
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("m_rst_req", 32'(bus.rst_req_o),
        32'(m_ph == PH_ASSERT || m_ph == PH_HOLD));
    chk("m_busy", 32'(bus.busy_o), 32'(m_ph != PH_IDLE));
    chk("m_cause", 32'(bus.cause_o), 32'(m_cause));
    chk("m_timeout", 32'(bus.timeout_o), 32'(m_tmo));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) m_reset();
    else m_step();
    #1;
    cmp_model();
    if (auto_ack) bus.ack_i = bus.rst_req_o;
  endtask

  task automatic finish_seq();
    auto_ack = 1'b1;
    for (int i = 0; i < 2 * T + 100; i++) begin
      if (!bus.busy_o) break;
      cyc();
    end
    chk("finish_bound", 32'(bus.busy_o), 0);
  endtask

  task automatic pulse_sw();
    bus.sw_req_i = 1'b1; cyc(); bus.sw_req_i = 1'b0;
  endtask

  int n, hi, seqs, idle;

  initial begin
    tbl[0] = '{sw:0, wdt:0, e_rst:0, e_busy:0, e_cause:2'b00};
    tbl[1] = '{sw:1, wdt:0, e_rst:1, e_busy:1, e_cause:2'b01};
    tbl[2] = '{sw:0, wdt:0, e_rst:0, e_busy:0, e_cause:2'b01};
    tbl[3] = '{sw:1, wdt:1, e_rst:1, e_busy:1, e_cause:2'b10};
    tbl[4] = '{sw:0, wdt:1, e_rst:1, e_busy:1, e_cause:2'b10};
    tbl[5] = '{sw:0, wdt:0, e_rst:0, e_busy:0, e_cause:2'b10};

    rst = 1'b1;
    bus.sw_req_i = 1'b0; bus.wdt_req_i = 1'b0; bus.ack_i = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_at_reset", 32'(bus.rst_req_o), 1);
    chk("busy_at_reset", 32'(bus.busy_o), 1);
    chk("cause_at_reset", 32'(bus.cause_o), 0);
    chk("timeout_at_reset", 32'(bus.timeout_o), 0);
    rst = 1'b0;

    // power-on: ack rises after 3 cycles, falls 2 cycles after release
    hi = 0;
    repeat (3) begin cyc(); if (bus.rst_req_o) hi++; end
    bus.ack_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (!bus.rst_req_o) break;
      hi++;
    end
    chk("por_req_len", hi, 3 + P);
    cyc();
    bus.ack_i = 1'b0;
    cyc();
    chk("por_busy", 32'(bus.busy_o), 0);
    chk("por_cause", 32'(bus.cause_o), 0);
    chk("por_timeout", 32'(bus.timeout_o), 0);

    // request vectors from IDLE
    for (int v = 0; v < 6; v++) begin
      bus.sw_req_i = tbl[v].sw; bus.wdt_req_i = tbl[v].wdt;
      cyc();
      bus.sw_req_i = 1'b0; bus.wdt_req_i = 1'b0;
      chk("tbl_rst_req", 32'(bus.rst_req_o), 32'(tbl[v].e_rst));
      chk("tbl_busy", 32'(bus.busy_o), 32'(tbl[v].e_busy));
      chk("tbl_cause", 32'(bus.cause_o), 32'(tbl[v].e_cause));
      if (bus.busy_o) finish_seq();
      cyc();
    end

    // sw during HOLD of a wdt sequence queues one SW sequence
    auto_ack = 1'b1;
    bus.wdt_req_i = 1'b1; cyc(); bus.wdt_req_i = 1'b0;
    repeat (5) cyc();
    pulse_sw();
    chk("hold_req_no_effect", 32'(bus.cause_o), 2);
    finish_seq();
    chk("pend_idle_gap", 32'(bus.busy_o), 0);
    cyc();
    chk("pend_restart", 32'(bus.busy_o), 1);
    chk("pend_cause", 32'(bus.cause_o), 1);
    finish_seq();
    repeat (5) cyc();
    chk("pend_single", 32'(bus.busy_o), 0);

    // wdt during ASSERT merges into the running reset
    auto_ack = 1'b0; bus.ack_i = 1'b0;
    pulse_sw();
    bus.wdt_req_i = 1'b1; cyc(); bus.wdt_req_i = 1'b0;
    chk("merge_cause", 32'(bus.cause_o), 2);
    finish_seq();
    repeat (5) cyc();
    chk("merge_no_pend", 32'(bus.busy_o), 0);

    // ack stuck high: RELEASE times out
    auto_ack = 1'b0; bus.ack_i = 1'b0;
    pulse_sw();
    bus.ack_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (!bus.rst_req_o) break;
    end
    n = 0;
    for (int i = 0; i < T + 20; i++) begin
      if (!bus.busy_o) break;
      cyc(); n++;
    end
    chk("rel_tmo_len", n, T);
    chk("rel_tmo_flag", 32'(bus.timeout_o), 1);
    bus.ack_i = 1'b0;
    cyc();

    // reset during RELEASE
    auto_ack = 1'b1;
    pulse_sw();
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (!bus.rst_req_o && bus.busy_o) break;
    end
    chk("mid_in_release", 32'(bus.rst_req_o), 0);
    rst = 1'b1;
    m_reset();
    #1;
    chk("mid_rst_req", 32'(bus.rst_req_o), 1);
    chk("mid_cause", 32'(bus.cause_o), 0);
    chk("mid_timeout", 32'(bus.timeout_o), 0);
    cyc(); cyc();
    rst = 1'b0;
    finish_seq();
    chk("mid_por_cause", 32'(bus.cause_o), 0);

    // ack tied low: ASSERT times out, then HOLD, then RELEASE exits
    auto_ack = 1'b0; bus.ack_i = 1'b0;
    pulse_sw();
    n = 0;
    for (int i = 0; i < T + 20; i++) begin
      if (bus.timeout_o) break;
      cyc(); n++;
    end
    chk("asrt_tmo_len", n, T);
    chk("asrt_tmo_req", 32'(bus.rst_req_o), 1);
    n = 0;
    for (int i = 0; i < P + 20; i++) begin
      if (!bus.rst_req_o) break;
      cyc(); n++;
    end
    chk("asrt_tmo_hold", n, P);
    cyc();
    chk("asrt_tmo_idle", 32'(bus.busy_o), 0);
    pulse_sw();
    finish_seq();
    chk("tmo_sticky", 32'(bus.timeout_o), 1);

    // level watchdog request: one IDLE cycle between sequences
    auto_ack = 1'b1;
    bus.wdt_req_i = 1'b1;
    seqs = 0; idle = 0;
    for (int i = 0; i < 600 && seqs < 3; i++) begin
      cyc();
      if (!bus.busy_o) idle++;
      else if (idle > 0) begin
        chk("level_gap", idle, 1);
        seqs++; idle = 0;
      end
    end
    chk("level_seqs", seqs, 3);
    bus.wdt_req_i = 1'b0;
    finish_seq();
    repeat (3) cyc();
    finish_seq();
    repeat (3) cyc();
    chk("level_drain", 32'(bus.busy_o), 0);

    // random traffic against the model
    auto_ack = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        rst = 1'b1;
        m_reset();
        #1;
        cmp_model();
        cyc();
        rst = 1'b0;
      end
      bus.sw_req_i  = ($urandom_range(0, 24) == 0);
      bus.wdt_req_i = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) bus.ack_i = 1'($urandom);
      else bus.ack_i = bus.rst_req_o;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
